// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one shift-and-conditional-subtract per cycle,
// start/ready/valid handshake. Define SEQ_DIVIDER_SIGNED_EN to add signed_i.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             signed_i,
`endif
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] divisor_q;
    logic [CNT_W-1:0] cnt;
    logic             neg_quot;
    logic             neg_rem;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand conditioning: signed operands are reduced to magnitudes up front.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        dvd_neg = 1'b0;
        dvs_neg = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        dvd_neg = signed_i & dividend_i[WIDTH-1];
        dvs_neg = signed_i & divisor_i[WIDTH-1];
`endif
        dvd_mag = dvd_neg ? ('0 - dividend_i) : dividend_i;
        dvs_mag = dvs_neg ? ('0 - divisor_i) : divisor_i;
    end

    // The shifted partial remainder can need WIDTH+1 bits, so the trial
    // subtract is one bit wider still and its top bit is the borrow.
    always_comb begin
        trial = {1'b0, r_q, q_q[WIDTH-1]} - {2'b00, divisor_q};
        if (trial[WIDTH+1]) begin
            r_next = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
            q_next = {q_q[WIDTH-2:0], 1'b0};
        end else begin
            r_next = trial[WIDTH-1:0];
            q_next = {q_q[WIDTH-2:0], 1'b1};
        end
        quot_fix = neg_quot ? ('0 - q_next) : q_next;
        rem_fix  = neg_rem  ? ('0 - r_next) : r_next;
    end

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            r_q           <= '0;
            q_q           <= '0;
            divisor_q     <= '0;
            cnt           <= '0;
            neg_quot      <= 1'b0;
            neg_rem       <= 1'b0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, matching the hardware.
            case (state)
                IDLE: begin
                    if (start_i) begin
                        div_by_zero_o <= (divisor_i == '0);
                        if (divisor_i == '0) begin
                            quotient_o  <= '1;
                            remainder_o <= dividend_i;
                            state       <= DONE;
                        end else begin
                            r_q       <= '0;
                            q_q       <= dvd_mag;
                            divisor_q <= dvs_mag;
                            cnt       <= '0;
                            neg_quot  <= dvd_neg ^ dvs_neg;
                            neg_rem   <= dvd_neg;
                            state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q <= r_next;
                    q_q <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        quotient_o  <= quot_fix;
                        remainder_o <= rem_fix;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model compared
// every cycle, plus directed vectors with hand-computed results and latencies.
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             start_i = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             signed_i = 1'b0;
`endif
    logic [WIDTH-1:0] dividend_i = '0;
    logic [WIDTH-1:0] divisor_i = '0;
    logic             ready_o;
    logic             valid_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div_by_zero_o;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_i      (signed_i),
`endif
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .ready_o       (ready_o),
        .valid_o       (valid_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the division rules.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                    output logic [31:0] q, output logic [31:0] r, output bit z);
        z = 1'b0;
        if (b == 32'd0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = 32'($signed(a) / $signed(b));
                r = 32'($signed(a) % $signed(b));
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Transaction-level model: a countdown to the result cycle, no datapath.
    logic        m_ready = 1'b1;
    logic        m_valid = 1'b0;
    logic [31:0] m_q = '0;
    logic [31:0] m_r = '0;
    logic        m_dbz = 1'b0;
    logic [31:0] p_q = '0;
    logic [31:0] p_r = '0;
    bit          p_z;
    int          wait_cnt = 0;

    always @(posedge clk_i or posedge rst_i) begin
        bit sgn;
        if (rst_i) begin
            m_ready = 1'b1; m_valid = 1'b0; m_q = '0; m_r = '0; m_dbz = 1'b0; wait_cnt = 0;
        end else if (m_valid) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
        end else if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
                m_valid = 1'b1;
                m_q = p_q; m_r = p_r; m_dbz = 1'b0;
            end
        end else if (start_i) begin
            sgn = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sgn = signed_i;
`endif
            ref_div(dividend_i, divisor_i, sgn, p_q, p_r, p_z);
            m_ready = 1'b0;
            m_dbz = 1'b0;
            if (p_z) begin
                m_valid = 1'b1;
                m_q = p_q; m_r = p_r; m_dbz = 1'b1;
            end else begin
                wait_cnt = WIDTH;
            end
        end
    end

    always @(negedge clk_i) begin
        check("cyc_ready", 64'(ready_o), 64'(m_ready));
        check("cyc_valid", 64'(valid_o), 64'(m_valid));
        check("cyc_quotient", 64'(quotient_o), 64'(m_q));
        check("cyc_remainder", 64'(remainder_o), 64'(m_r));
        check("cyc_dbz", 64'(div_by_zero_o), 64'(m_dbz));
    end

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
        check({name, "_idle_timeout"}, 64'(ok), 64'd1);
    endtask

    // Issue one division, scramble operands after acceptance, measure latency
    // in cycles from the start cycle, and compare against literal expectations.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                           input logic [31:0] eq, input logic [31:0] er, input bit ez,
                           input int elat, input string name);
        int  cyc;
        bit  seen = 1'b0;
        wait_idle(name);
        start_i = 1'b1;
        dividend_i = a;
        divisor_i = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_i = sgn;
`endif
        @(posedge clk_i); #1;
        start_i = 1'b0;
        dividend_i = $urandom;
        divisor_i = $urandom;
        cyc = 1;
        check({name, "_dbz_on_accept"}, 64'(div_by_zero_o), 64'(b == 32'd0));
        for (int k = 0; k < 100; k++) begin
            if (valid_o) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        check({name, "_latency"}, seen ? 64'(cyc) : 64'hFFFF, 64'(elat));
        check({name, "_quotient"}, 64'(quotient_o), 64'(eq));
        check({name, "_remainder"}, 64'(remainder_o), 64'(er));
        check({name, "_dbz"}, 64'(div_by_zero_o), 64'(ez));
    endtask

    initial begin
        int nvalid;
        int vcyc[$];

        #2 rst_i = 1'b1;
        #1;
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_quotient", 64'(quotient_o), 64'd0);
        check("rst_remainder", 64'(remainder_o), 64'd0);
        check("rst_dbz", 64'(div_by_zero_o), 64'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;

        run_div(32'h0000_3039, 32'h0000_1A85, 1'b0, 32'd1, 32'd5556, 1'b0, 33, "basic");

        // Abort a division mid-flight after ten iterations.
        wait_idle("abort");
        start_i = 1'b1; dividend_i = 32'd100; divisor_i = 32'd7;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        check("abort_quotient", 64'(quotient_o), 64'd0);
        check("abort_remainder", 64'(remainder_o), 64'd0);
        check("abort_ready", 64'(ready_o), 64'd1);
        check("abort_valid", 64'(valid_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        nvalid = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (valid_o) nvalid++;
        end
        check("abort_no_valid", 64'(nvalid), 64'd0);

        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, "after_rst");
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, "max_by_one");
        run_div(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 33, "small_by_big");
        run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 1'b0, 33, "wide_divisor");
        run_div(32'h0000_000A, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd10, 1'b1, 1, "div_zero");
        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, "flag_clear");

        // Start held high with operands changing every cycle.
        start_i = 1'b1;
        for (int i = 0; i < 110; i++) begin
            dividend_i = 32'(i * 40503 + 977);
            divisor_i = 32'((i * 37) % 1000 + 1);
            @(posedge clk_i); #1;
            if (valid_o) vcyc.push_back(i);
        end
        start_i = 1'b0;
        check("b2b_pulses", 64'(vcyc.size()), 64'd3);
        for (int k = 0; k + 1 < vcyc.size(); k++)
            check("b2b_period", 64'(vcyc[k+1] - vcyc[k]), 64'd34);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, "s_neg7_2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, "s_minneg");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, "s_7_neg2");
        run_div(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1, "s_div_zero");
`endif

        wait_idle("final");
        repeat (3) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider for the datapath. Each iteration performs one shift-and-conditional-subtract step.
- Computes the quotient and remainder of two WIDTH-bit operands.
- Uses a start/ready/valid handshake so the issuing control logic can launch one division and collect the result later.
- Sits beside the add/subtract unit and provides the inverse (division) direction of the arithmetic path.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- start_i  input  1  launch a division; accepted only when ready_o=1.
- dividend_i  input  WIDTH  dividend; sampled on an accepted start.
- divisor_i  input  WIDTH  divisor; sampled on an accepted start.
- ready_o  output  1  unit is idle and can accept start_i.
- valid_o  output  1  one-cycle pulse; quotient_o and remainder_o are valid.
- quotient_o  output  WIDTH  quotient; held until the next accepted start.
- remainder_o  output  WIDTH  remainder; held until the next accepted start.
- div_by_zero_o  output  1  set with valid_o when the divisor was 0; held with the results.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE.
  - ready_o=1, valid_o=0, div_by_zero_o=0.
  - quotient_o=0, remainder_o=0.
  - Internal registers and counter cleared.
- Reset mid-operation aborts the division immediately; no valid_o is produced.
- States are IDLE, CALC, DONE.
- IDLE:
  - ready_o=1.
  - If start_i=1, latch the operands and clear div_by_zero_o.
  - If divisor_i==0, go to DONE.
  - Otherwise load remainder register (partial remainder) R=0, quotient register Q=dividend, cnt=0, and go to CALC.
  - start_i=0 leaves the unit in IDLE.
- CALC:
  - ready_o=0.
  - Each cycle: {R,Q} shifted left by 1; T = R_shifted − divisor computed at WIDTH+1 bits.
  - If T is non-negative (MSB of T = 0): R = T[WIDTH-1:0] and Q[0]=1. Otherwise R is unchanged and Q[0]=0.
  - cnt increments each cycle; after WIDTH iterations go to DONE.
- DONE:
  - Occupies one cycle; ready_o=0 and valid_o=1.
  - quotient_o and remainder_o are updated on DONE entry.
  - Then return to IDLE.
- Divide by zero:
  - quotient_o = all ones, remainder_o = dividend.
  - div_by_zero_o=1.
- Latency:
  - Normal division: start accepted on cycle N → valid_o asserted on cycle N+WIDTH+1.
  - Divide by zero: valid_o asserted on cycle N+1.
- start_i while ready_o=0 is ignored; no queueing.
- start_i in the same cycle as the DONE→IDLE transition is ignored, because ready_o=0 in DONE.
- Outputs change only on DONE entry or reset.
- Arithmetic is unsigned by default; the subtract uses a WIDTH+1-bit result so the borrow decides the quotient bit.
- divisor > dividend gives quotient 0, remainder = dividend.
- Operand changes after acceptance have no effect.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- When defined:
  - Adds input port signed_i (1 bit), sampled with start_i.
  - If signed_i=1, operands are two's complement. The unit divides their magnitudes, then negates the results in DONE.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative / −1 gives quotient = most-negative value, remainder = 0, with no flag.
  - Signed divide by zero gives quotient = all ones, remainder = dividend.
  - Latency is unchanged.
- When undefined: no signed_i port; all division is unsigned.

Test Plan:
- Reset:
  - Stimulus: assert rst_i mid-CALC (dividend 100, divisor 7, cnt=10).
  - Required response: outputs go to 0 immediately, ready_o=1, no valid_o pulse.
  - After release: a new start with 100/7 gives quotient 14, remainder 2.
- Basic division and latency:
  - Stimulus: dividend 32'h00003039 (12345), divisor 32'h00001A85 (6789).
  - Required response: quotient 1, remainder 5556; valid_o exactly 33 cycles after the start cycle; ready_o=0 in between.
- Wide operands and boundary:
  - Stimulus: dividend 32'hFFFFFFFF, divisor 1. Required response: quotient 32'hFFFFFFFF, remainder 0.
  - Stimulus: dividend 5, divisor 9. Required response: quotient 0, remainder 5.
- Divide by zero:
  - Stimulus: dividend 32'h0000000A, divisor 0.
  - Required response: valid_o on the next cycle, quotient 32'hFFFFFFFF, remainder 10, div_by_zero_o=1.
  - The flag clears on the next accepted start.
- Handshake:
  - Stimulus: start_i held high continuously with operand changes during CALC.
  - Required response: those changes are ignored; back-to-back divisions issue every 34 cycles; results are held stable between valid_o pulses.
- Signed division (SEQ_DIVIDER_SIGNED_EN defined):
  - Stimulus: −7/2. Required response: quotient −3, remainder −1.
  - Stimulus: 32'h80000000/32'hFFFFFFFF. Required response: quotient 32'h80000000, remainder 0.
